// File: rtl/disp_pkg.sv
// Shared definitions for the result display path.
//
// Holds the BCD digit geometry, the digit-select encodings used on the
// display `count` bus, the double-dabble adjust constants and the state
// encoding of the sequential binary-to-BCD core.
package disp_pkg;

    // Width of one BCD digit and the number of magnitude digits shown.
    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 3;
    localparam int BCD_BUS_W  = BCD_W * NUM_DIGITS;

    // Digit-select positions on the display refresh bus.
    typedef enum logic [1:0] {
        DIG_ONES = 2'd0,
        DIG_TENS = 2'd1,
        DIG_HUND = 2'd2,
        DIG_SIGN = 2'd3
    } dig_sel_e;

    // A nibble at or above the threshold would exceed 9 after the next
    // shift, so it is pre-corrected by the offset before shifting.
    localparam int DD_THRESH = 5;
    localparam int DD_OFFSET = 3;

    // Conversion core states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } conv_state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/adjust step per clock.
//
// Ports:
//   clk    - rising-edge clock
//   srst   - synchronous active-high reset; aborts a running conversion
//   start  - begin converting `bin` (honoured only while idle)
//   bin    - unsigned binary input, BITS wide
//   busy   - conversion in progress
//   done   - one-cycle pulse in the cycle after the final step
//   last   - high during the cycle whose edge performs the final step
//   bcd    - result of the step being performed this cycle; holds the
//            finished digits {hundreds, tens, ones} while `last` is high
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int BITS = 9
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 start,
    input  logic [BITS-1:0]      bin,
    output logic                 busy,
    output logic                 done,
    output logic                 last,
    output logic [BCD_BUS_W-1:0] bcd
);

    localparam int CNT_W = $clog2(BITS + 1);

    conv_state_e          state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [BITS-1:0]      mag_reg, mag_next;
    logic [BCD_BUS_W-1:0] scratch_reg, scratch_next;
    logic                 done_reg, done_next;
    logic [BCD_BUS_W-1:0] adjusted;
    logic [BCD_BUS_W-1:0] stepped;

    // Per-digit add-3 correction applied before the shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adjust
            logic [BCD_W-1:0] nib;
            assign nib = scratch_reg[gi*BCD_W +: BCD_W];
            assign adjusted[gi*BCD_W +: BCD_W] =
                (nib >= BCD_W'(DD_THRESH)) ? nib + BCD_W'(DD_OFFSET) : nib;
        end
    endgenerate

    // Shift left, taking in the magnitude MSB. The value never exceeds
    // 999, so nothing meaningful leaves the top of the scratch.
    assign stepped = (adjusted << 1) | {{(BCD_BUS_W-1){1'b0}}, mag_reg[BITS-1]};

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            mag_reg     <= '0;
            scratch_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mag_reg     <= mag_next;
            scratch_reg <= scratch_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mag_next     = mag_reg;
        scratch_next = scratch_reg;
        done_next    = 1'b0;
        last         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    mag_next     = bin;
                    scratch_next = '0;
                    cnt_next     = CNT_W'(BITS);
                    state_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                scratch_next = stepped;
                mag_next     = mag_reg << 1;
                cnt_next     = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    last       = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg == ST_RUN);
    assign done = done_reg;
    assign bcd  = stepped;

endmodule

// File: rtl/result_display_driver.sv
// Signed result to multiplexed BCD display driver.
//
// Captures a signed value on `load`, converts its magnitude to three BCD
// digits over WIDTH+1 clocks, then commits digits and sign atomically.
// A free-running prescaler steps `count` through the four display
// positions every REFRESH_DIV clocks; `num` carries the selected digit.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   value    - signed two's-complement input, WIDTH bits
//   load     - capture request (ignored while busy)
//   busy     - conversion in progress
//   done     - one-cycle pulse when new digits are committed
//   en       - display enable, set by the first completed conversion
//   count    - digit select: ones, tens, hundreds, sign position
//   num      - BCD digit selected by count (0 in the sign position)
//   sign     - committed result is negative
module result_display_driver
    import disp_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             en,
    output logic [1:0]       count,
    output logic [3:0]       num,
    output logic             sign
);

    // One extra bit so that -2^(WIDTH-1) negates to a positive magnitude.
    localparam int MAG_W = WIDTH + 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [MAG_W-1:0]     val_ext;
    logic [MAG_W-1:0]     mag;
    logic                 start;
    logic                 core_busy;
    logic                 core_done;
    logic                 core_last;
    logic [BCD_BUS_W-1:0] core_bcd;

    logic [BCD_BUS_W-1:0] digit_reg;
    logic                 sign_reg;
    logic                 sign_pend_reg;
    logic                 en_reg;
    logic [PRE_W-1:0]     presc_reg;
    logic [1:0]           count_reg;

    assign val_ext = {value[WIDTH-1], value};
    assign mag     = value[WIDTH-1] ? -val_ext : val_ext;
    assign start   = load && !core_busy;

    bin2bcd_seq #(
        .BITS (MAG_W)
    ) u_conv (
        .clk   (clk),
        .srst  (rst),
        .start (start),
        .bin   (mag),
        .busy  (core_busy),
        .done  (core_done),
        .last  (core_last),
        .bcd   (core_bcd)
    );

    // Sign is held pending until the digits are ready so the display
    // switches sign and magnitude on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_reg     <= '0;
            sign_reg      <= 1'b0;
            sign_pend_reg <= 1'b0;
            en_reg        <= 1'b0;
        end else begin
            if (start) begin
                sign_pend_reg <= value[WIDTH-1];
            end
            if (core_last) begin
                digit_reg <= core_bcd;
                sign_reg  <= sign_pend_reg;
                en_reg    <= 1'b1;
            end
        end
    end

    // Display refresh: runs regardless of conversion activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
            count_reg <= 2'd0;
        end else if (presc_reg == PRE_W'(REFRESH_DIV - 1)) begin
            presc_reg <= '0;
            count_reg <= count_reg + 2'd1;
        end else begin
            presc_reg <= presc_reg + PRE_W'(1);
        end
    end

    always_comb begin
        num = 4'd0;
        case (count_reg)
            DIG_ONES: num = digit_reg[0*BCD_W +: BCD_W];
            DIG_TENS: num = digit_reg[1*BCD_W +: BCD_W];
            DIG_HUND: num = digit_reg[2*BCD_W +: BCD_W];
            default:  num = 4'd0;
        endcase
    end

    assign busy  = core_busy;
    assign done  = core_done;
    assign en    = en_reg;
    assign count = count_reg;
    assign sign  = sign_reg;

endmodule

// File: doc/result_display_driver.md
Name: result_display_driver

Overview:
- Upstream stage of the BCD_to_7seg decoder; sits between the signed arithmetic result and the display decoder.
- Captures a signed two's-complement result on a load strobe and converts its magnitude to three BCD digits with a sequential double-dabble engine.
- Holds the converted digits and sign, runs the display refresh counter, and presents the digit selected by that counter on `num` with the matching `count`, `sign` and `en`.

Parameters:
WIDTH, 8, width of signed input `value`; legal range 4..10, so |value| ≤ 512 always fits three BCD digits.
REFRESH_DIV, 100000, clock cycles per displayed digit; legal range ≥ 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- value  in  WIDTH  signed two's-complement result to display.
- load  in  1  capture request; sampled on the rising edge.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- en  out  1  display enable; 0 until the first conversion completes.
- count  out  2  digit select: 0 = ones, 1 = tens, 2 = hundreds, 3 = sign position.
- num  out  4  BCD digit selected by count; 0 when count = 3.
- sign  out  1  1 = committed result is negative.

Behaviour:
- Reset (rst = 1 at an edge):
  - busy, done, en, sign all go to 0; count = 0; num = 0.
  - Digit registers and prescaler clear.
  - A conversion in flight is aborted and no partial result is ever committed.
- Idle, load = 1:
  - Capture sign = value[WIDTH-1] into the pending sign.
  - Capture magnitude = sign ? -value : value, computed in WIDTH+1 bits so that value = -2^(WIDTH-1) gives 2^(WIDTH-1).
  - Clear the BCD scratch and set step counter = WIDTH+1. busy = 1 from the next cycle.
- Busy: each edge performs one double-dabble step on the scratch:
  - Add 3 to any BCD nibble ≥ 5.
  - Shift left one bit, taking in the magnitude MSB.
  - Decrement the step counter.
- Final step (counter 1 → 0):
  - The step result is written directly to the committed hundreds/tens/ones registers and the pending sign to the committed sign.
  - busy → 0; done = 1 for exactly one cycle; en → 1 and stays 1 until reset.
- Latency: digits are visible WIDTH+1 edges after the load edge; the next load is accepted in the cycle done is high.
- Display holds the old digits throughout a conversion; the update is atomic, so there are never mixed old/new digits.
- load while busy: ignored, no queuing.
- load coincident with the final step: ignored, because busy is still 1 that cycle.
- Positive zero: sign = 0. Input 0 yields digits 0/0/0.
- Refresh:
  - Prescaler counts 0..REFRESH_DIV-1 continuously, independent of busy and en.
  - At terminal count the prescaler wraps to 0 and count increments, wrapping 3 → 0.
- Output mux (combinational from registers): num = ones / tens / hundreds for count = 0 / 1 / 2, and 0 for count = 3. `sign` output = committed sign.
- No X on any output after the first reset edge.

Decomposition:
- Shared package `disp_pkg`:
  - BCD digit width (4).
  - Digit count (3).
  - Digit-select encodings (DIG_ONES = 0, DIG_TENS = 1, DIG_HUND = 2, DIG_SIGN = 3).
  - Double-dabble adjust threshold (5) and offset (3).
- One natural sub-module `bin2bcd_seq`:
  - Contents: sequential double-dabble core with start, busy, done and 12-bit BCD output.
  - Owned by the parent: capture, sign/magnitude, commit, prescaler and mux.

Test Plan:
1. rst held 3 cycles mid-conversion of value = 8'sd99 → busy = 0, en = 0, count = 0, num = 0, done never pulses.
2. WIDTH = 8, load value = 8'sd123 → done pulses 9 edges after the load edge. Sweeping count 0..3 gives num = 3, 2, 1, 0; sign = 0; en = 1.
3. load value = 8'h80 (−128) → digits 8/2/1, sign = 1. Then load 8'sd0 → digits 0/0/0, sign = 0.
4. load value = −7 and, while busy, load = 1 with value = 55 → committed digits 7/0/0, sign = 1. The second load is ignored, including one asserted in the done-minus-one cycle.
5. REFRESH_DIV = 4 → count advances every 4 cycles: sequence 0, 1, 2, 3, 0 over 16 cycles. Digits keep their old values until a new conversion's done cycle.
6. Back-to-back: load −45 and, in the done cycle, load 67 → second result 7/6/0, sign = 0, done after another 9 edges.
